pov_column_scheduler: RTL and testbench

//  Turns the once-per-revolution encoder index into evenly spaced per-column

---
 rtl/pov_column_scheduler.sv | 152 +++++++++++++++
 tb/tb_pov_column_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pov_column_scheduler.sv
// POV column scheduler: measures rotation period from the encoder index
// and issues one evenly spaced column strobe per slot to the LED driver.
module pov_column_scheduler #(
  parameter int NUM_COLS   = 64,
  parameter int PERIOD_W   = 26,
  parameter int MIN_PERIOD = 100000
) (
  input  logic                        sys_clk,
  input  logic                        Reset,
  input  logic                        index_in,
  input  logic                        enable,
  input  logic                        drv_busy,
  output logic                        write_data,
  output logic [$clog2(NUM_COLS)-1:0] col_idx,
  output logic                        locked,
  output logic [PERIOD_W-1:0]         period,
  output logic                        overrun
);

  localparam int CW = $clog2(NUM_COLS);
  localparam logic [CW-1:0] LAST = CW'(NUM_COLS - 1);
  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] RUN     = 2'd2;

  logic [2:0]          sync;
  logic                idx_pulse;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] timer;
  logic [1:0]          state;
  logic                pending;

  logic                cnt_sat;
  logic                accept;
  logic                abort;
  logic [PERIOD_W-1:0] slot_new;
  logic [PERIOD_W-1:0] slot_cur;

  logic [1:0]          state_nxt;
  logic [CW-1:0]       col_nxt;
  logic [PERIOD_W-1:0] timer_nxt;
  logic [PERIOD_W-1:0] period_nxt;
  logic                restart;
  logic                due;
  logic                pend_nxt;
  logic                wr_nxt;
  logic                ovr_nxt;

  assign cnt_sat  = &cnt;
  assign accept   = idx_pulse & enable &
                    ((cnt >= MIN_P) | (state == IDLE));
  assign abort    = !enable | (cnt_sat & (state != IDLE));
  assign slot_new = cnt >> CW;
  assign slot_cur = period >> CW;
  assign locked   = (state == RUN);

  always_comb begin
    state_nxt  = state;
    col_nxt    = col_idx;
    timer_nxt  = timer;
    period_nxt = period;
    restart    = 1'b0;
    due        = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) state_nxt = MEASURE;
        end
        MEASURE: begin
          if (accept) begin
            period_nxt = cnt;
            if (slot_new != '0) begin
              state_nxt = RUN;
              restart   = 1'b1;
            end
          end
        end
        RUN: begin
          if (accept) begin
            period_nxt = cnt;
            if (slot_new != '0) restart = 1'b1;
            else state_nxt = MEASURE;
          end else if (timer == '0) begin
            // after the last column hold until the next index
            if (col_idx != LAST) begin
              col_nxt   = col_idx + CW'(1);
              timer_nxt = slot_cur - ONE;
              due       = 1'b1;
            end
          end else begin
            timer_nxt = timer - ONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    if (restart) begin
      col_nxt   = '0;
      timer_nxt = slot_new - ONE;
      due       = 1'b1;
    end
  end

  // a newly due column always replaces a strobe still waiting on the driver
  always_comb begin
    pend_nxt = pending;
    wr_nxt   = 1'b0;
    ovr_nxt  = 1'b0;
    if (abort) begin
      pend_nxt = 1'b0;
    end else if (due) begin
      ovr_nxt  = pending;
      pend_nxt = 1'b1;
    end else if (pending && !drv_busy) begin
      wr_nxt   = 1'b1;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge Reset) begin
    if (Reset) begin
      sync       <= '0;
      idx_pulse  <= 1'b0;
      cnt        <= ONE;
      timer      <= '0;
      state      <= IDLE;
      period     <= '0;
      col_idx    <= '0;
      pending    <= 1'b0;
      write_data <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync       <= {sync[1:0], index_in};
      idx_pulse  <= sync[1] & ~sync[2];
      if (accept && !abort) cnt <= ONE;
      else if (!cnt_sat) cnt <= cnt + ONE;
      timer      <= timer_nxt;
      state      <= state_nxt;
      period     <= period_nxt;
      col_idx    <= col_nxt;
      pending    <= pend_nxt;
      write_data <= wr_nxt;
      overrun    <= ovr_nxt;
    end
  end

endmodule

// File: tb/tb_pov_column_scheduler.sv
// Directed bench for pov_column_scheduler (8 columns, 12-bit period).
// Strobes and overruns are logged per cycle and checked against fixed times.
module tb_pov_column_scheduler;

  logic        sys_clk = 1'b0;
  logic        Reset = 1'b1;
  logic        index_in = 1'b0;
  logic        enable = 1'b1;
  logic        drv_busy = 1'b0;
  logic        write_data;
  logic [2:0]  col_idx;
  logic        locked;
  logic [11:0] period;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int s_cyc[$];
  int s_col[$];
  int o_cyc[$];

  pov_column_scheduler #(
    .NUM_COLS(8), .PERIOD_W(12), .MIN_PERIOD(16)
  ) dut (
    .sys_clk(sys_clk),
    .Reset(Reset),
    .index_in(index_in),
    .enable(enable),
    .drv_busy(drv_busy),
    .write_data(write_data),
    .col_idx(col_idx),
    .locked(locked),
    .period(period),
    .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    #1;
    if (write_data) begin
      s_cyc.push_back(cyc);
      s_col.push_back(int'(col_idx));
    end
    if (overrun) o_cyc.push_back(cyc);
  end

  task automatic check(string tag, int got, int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) @(negedge sys_clk);
  endtask

  task automatic index_at(int c);
    wait_until(c);
    index_in = 1'b1;
    wait_until(c + 2);
    index_in = 1'b0;
  endtask

  function automatic int col_at(int c);
    foreach (s_cyc[i]) if (s_cyc[i] == c) return s_col[i];
    return -1;
  endfunction

  function automatic int n_strobes(int a, int b);
    int n = 0;
    foreach (s_cyc[i]) if (s_cyc[i] >= a && s_cyc[i] <= b) n++;
    return n;
  endfunction

  function automatic int n_ovr(int a, int b);
    int n = 0;
    foreach (o_cyc[i]) if (o_cyc[i] >= a && o_cyc[i] <= b) n++;
    return n;
  endfunction

  initial begin
    // 1: reset held while inputs toggle
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      index_in = ~index_in;
      drv_busy = ~drv_busy;
      if (i % 3 == 0) begin
        check("rst_wr", int'(write_data), 0);
        check("rst_col", int'(col_idx), 0);
        check("rst_lock", int'(locked), 0);
        check("rst_per", int'(period), 0);
        check("rst_ovr", int'(overrun), 0);
      end
    end
    index_in = 1'b0;
    drv_busy = 1'b0;
    wait_until(20);
    Reset = 1'b0;
    wait_until(99);
    check("idle_strobes", n_strobes(0, 99), 0);
    check("idle_lock", int'(locked), 0);

    // 2: two indices 800 apart lock the scheduler
    index_at(100);
    wait_until(850);
    check("meas_lock", int'(locked), 0);
    index_at(900);
    wait_until(910);
    check("lock", int'(locked), 1);
    check("period800", int'(period), 800);
    check("meas_strobes", n_strobes(0, 904), 0);

    // 3: glitch shortly after an accepted edge
    index_at(1700);
    wait_until(1705);
    index_in = 1'b1;
    wait_until(1707);
    index_in = 1'b0;
    wait_until(1800);
    check("glitch_per", int'(period), 800);
    check("glitch_lock", int'(locked), 1);

    // 4: driver busy across the col 2 -> col 3 boundary
    index_at(2500);
    wait_until(2704);
    drv_busy = 1'b1;
    wait_until(2854);
    drv_busy = 1'b0;

    // 5: early index at 640 cycles
    index_at(3140);
    wait_until(3144);
    check("early_col", int'(col_idx), 0);
    check("early_per", int'(period), 640);

    // 6: index stops, counter saturates, then relock
    wait_until(7238);
    check("sat_before", int'(locked), 1);
    wait_until(7239);
    check("sat_unlock", int'(locked), 0);
    index_at(7400);
    wait_until(8000);
    check("relock_meas", int'(locked), 0);
    index_at(8200);
    wait_until(8210);
    check("relock", int'(locked), 1);
    check("relock_per", int'(period), 800);

    // revolution logs
    check("rev1_n", n_strobes(905, 1704), 8);
    for (int k = 0; k < 8; k++)
      check("rev1_col", col_at(905 + 100 * k), k);
    check("rev2_n", n_strobes(1705, 2504), 8);
    check("rev2_c0", col_at(1705), 0);
    check("rev2_c7", col_at(2405), 7);
    check("busy_gap", n_strobes(2606, 2854), 0);
    check("busy_c1", col_at(2605), 1);
    check("ovr_at", n_ovr(2804, 2804), 1);
    check("ovr_n", n_ovr(0, 8300), 1);
    check("busy_c3", col_at(2855), 3);
    check("busy_c4", col_at(2905), 4);
    check("pre_early_c6", col_at(3105), 6);
    check("early_c0", col_at(3145), 0);
    check("early_c1", col_at(3225), 1);
    check("early_c7", col_at(3705), 7);
    check("early_n", n_strobes(3145, 3705), 8);
    check("dead_n", n_strobes(3706, 8204), 0);
    check("relock_c0", col_at(8205), 0);

    // asynchronous reset mid-run
    wait_until(8300);
    Reset = 1'b1;
    #1;
    check("arst_lock", int'(locked), 0);
    check("arst_per", int'(period), 0);
    check("arst_col", int'(col_idx), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
